// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end sitting between the PC/IMEM and the decode
// stage. It owns the fetch PC, issues single-word reads to the instruction
// memory and buffers returned words, each tagged with its PC, in a small
// FIFO. Decode sees the head of that FIFO and pops one entry per cycle
// unless it stalls, so load-use stalls are absorbed without re-fetching.
// A taken branch/jump from execute flushes the FIFO and any in-flight read
// and restarts fetch at the redirect target.
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   i_address      IMEM read address (always the current fetch PC)
//   i_access_size  IMEM access size, fixed single word (2'b00)
//   i_rw           IMEM direction, fixed read (1)
//   i_mem_enable   IMEM request strobe, sampled at the end of the cycle
//   i_busy         IMEM cannot accept a request this cycle
//   i_data_in      IMEM read data, valid the cycle after an accepted request
//   stall          decode is holding the head entry
//   do_branch      taken branch/jump from execute
//   pc_effective   redirect target, valid with do_branch
//   pc_out         PC of the head entry (0 when empty)
//   insn_out       head instruction, NOP_INSN when empty
//   valid_out      head entry is valid
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSN  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] i_address,
  output logic [1:0]  i_access_size,
  output logic        i_rw,
  output logic        i_mem_enable,
  input  logic        i_busy,
  input  logic [31:0] i_data_in,
  input  logic        stall,
  input  logic        do_branch,
  input  logic [31:0] pc_effective,
  output logic [31:0] pc_out,
  output logic [31:0] insn_out,
  output logic        valid_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0] insn_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];

  logic           pop;
  logic           push;
  logic           issue;
  logic [CNT_W:0] credit_used;

  // Head entry drives decode directly; pc_out/insn_out fall back to fixed
  // values when there is nothing to present so decode never sees stale data.
  assign valid_out = (count != '0);
  assign pc_out    = valid_out ? pc_q[head]   : 32'h0;
  assign insn_out  = valid_out ? insn_q[head] : NOP_INSN;

  assign pop  = valid_out & ~stall;
  // A response only lands in the queue if no redirect kills it this cycle.
  assign push = inflight & ~do_branch;

  // Credits already committed: entries held plus the read still out,
  // minus the entry leaving this cycle. Counting the departing entry lets
  // a full queue keep issuing back-to-back while decode drains it. pop
  // implies count >= 1, so the subtraction never underflows.
  assign credit_used = {1'b0, count}
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, pop};

  // Gated with reset_n so no request strobe escapes while reset is held.
  assign issue = reset_n & ~do_branch & ~i_busy & (credit_used < CREDIT_MAX);

  assign i_mem_enable  = issue;
  assign i_address     = fetch_pc;
  assign i_access_size = 2'b00;
  assign i_rw          = 1'b1;

  // Control state: fetch PC, in-flight tracking, queue pointers and count.
  // A redirect wins over every other event in the same cycle, and clearing
  // inflight on reset is what discards a response to a pre-reset request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= BASE_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (do_branch) begin
      fetch_pc <= pc_effective;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      inflight <= issue;

      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; entries are only visible through
  // valid_out, which depends solely on the reset count.
  always_ff @(posedge clock) begin
    if (push) begin
      insn_q[tail] <= i_data_in;
      pc_q[tail]   <= inflight_pc;
    end
  end

  // The issue credit rule must never let a response arrive into a full
  // queue that is not draining in the same cycle.
  a_no_overflow : assert property (
    @(posedge clock) disable iff (!reset_n)
      !(push && !pop && (count == FULL_COUNT))
  );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Drives fetch_queue with directed sequences followed by a randomized run,
// and compares every cycle's outputs against a transaction-level model that
// keeps the buffered instructions in a queue of (pc, word) pairs, a single
// outstanding-read record and the next fetch address.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clock;
  logic        reset_n;
  logic [31:0] i_address;
  logic [1:0]  i_access_size;
  logic        i_rw;
  logic        i_mem_enable;
  logic        i_busy;
  logic [31:0] i_data_in;
  logic        stall;
  logic        do_branch;
  logic [31:0] pc_effective;
  logic [31:0] pc_out;
  logic [31:0] insn_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] model_pc_q[$];
  logic [31:0] model_insn_q[$];
  bit          model_inflight;
  logic [31:0] model_inflight_pc;
  logic [31:0] model_fetch_pc;
  logic [31:0] last_issued_pc;

  fetch_queue #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .NOP_INSN  (NOP)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_address     (i_address),
    .i_access_size (i_access_size),
    .i_rw          (i_rw),
    .i_mem_enable  (i_mem_enable),
    .i_busy        (i_busy),
    .i_data_in     (i_data_in),
    .stall         (stall),
    .do_branch     (do_branch),
    .pc_effective  (pc_effective),
    .pc_out        (pc_out),
    .insn_out      (insn_out),
    .valid_out     (valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: a scrambled function of the address so a word can
  // never be confused with its own PC.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    model_pc_q.delete();
    model_insn_q.delete();
    model_inflight    = 0;
    model_inflight_pc = 32'h0;
    model_fetch_pc    = BASE;
  endtask

  // One clock cycle: drive inputs just after the falling edge, check the
  // settled outputs against the model, advance the model, then move to the
  // next falling edge. When no read is outstanding the memory bus carries
  // the most recently fetched word so a spurious capture looks plausible.
  task automatic applyStimulus(input bit s, input bit b, input bit br,
                               input logic [31:0] tgt);
    bit          exp_valid;
    bit          exp_pop;
    bit          exp_issue;
    int          credits;
    stall        = s;
    i_busy       = b;
    do_branch    = br;
    pc_effective = tgt;
    i_data_in    = model_inflight ? memWord(model_inflight_pc)
                                  : memWord(last_issued_pc);
    #1;
    exp_valid = (model_pc_q.size() != 0);
    exp_pop   = exp_valid && !s;
    credits   = model_pc_q.size() + int'(model_inflight) - int'(exp_pop);
    exp_issue = !br && !b && (credits < DEPTH);

    checkOutput("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
    checkOutput("insn_out", insn_out, exp_valid ? model_insn_q[0] : NOP);
    if (exp_valid) begin
      checkOutput("pc_out", pc_out, model_pc_q[0]);
    end
    checkOutput("i_mem_enable", {31'b0, i_mem_enable}, {31'b0, exp_issue});
    checkOutput("i_address", i_address, model_fetch_pc);

    if (br) begin
      model_pc_q.delete();
      model_insn_q.delete();
      model_inflight = 0;
      model_fetch_pc = tgt;
    end else begin
      if (exp_pop) begin
        void'(model_pc_q.pop_front());
        void'(model_insn_q.pop_front());
      end
      if (model_inflight) begin
        model_pc_q.push_back(model_inflight_pc);
        model_insn_q.push_back(memWord(model_inflight_pc));
      end
      model_inflight = exp_issue;
      if (exp_issue) begin
        model_inflight_pc = model_fetch_pc;
        last_issued_pc    = model_fetch_pc;
        model_fetch_pc    = model_fetch_pc + 32'd4;
      end
    end

    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_valid"}, {31'b0, valid_out}, 32'h0);
    checkOutput({phase, "_insn"}, insn_out, NOP);
    checkOutput({phase, "_pc"}, pc_out, 32'h0);
    checkOutput({phase, "_enable"}, {31'b0, i_mem_enable}, 32'h0);
    checkOutput({phase, "_address"}, i_address, BASE);
  endtask

  initial begin
    reset_n        = 1'b0;
    stall          = 1'b0;
    i_busy         = 1'b0;
    do_branch      = 1'b0;
    pc_effective   = 32'h0;
    i_data_in      = 32'h0;
    last_issued_pc = BASE;
    modelReset();

    // Power-on reset values
    @(negedge clock);
    @(negedge clock);
    checkResetOutputs("reset");
    checkOutput("i_access_size", {30'b0, i_access_size}, 32'h0);
    checkOutput("i_rw", {31'b0, i_rw}, 32'h1);
    reset_n = 1'b1;
    $display("[TB] streaming after reset");

    // Free-running fetch, one instruction per cycle
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);

    // Decode holds: queue fills to DEPTH and requests stop
    $display("[TB] stall fill and drain");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);

    // Redirect with a partly filled queue and a read outstanding
    $display("[TB] redirect cases");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h8002_0100);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

    // Redirect together with a stall still flushes
    applyStimulus(1, 0, 1, 32'h8002_0200);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);

    // Fetch PC wraps past the top of the address space
    applyStimulus(0, 0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0);

    // Unaligned target is used as given
    applyStimulus(0, 0, 1, 32'h8002_0302);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);

    // Memory busy mid-stream
    $display("[TB] memory busy");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

    // Asynchronous reset between edges with a read outstanding
    $display("[TB] asynchronous reset");
    applyStimulus(1, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

    // Randomized traffic
    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      bit          s;
      bit          b;
      bit          br;
      logic [31:0] tgt;
      s   = ($urandom_range(0, 99) < 35);
      b   = ($urandom_range(0, 99) < 25);
      br  = ($urandom_range(0, 99) < 6);
      tgt = {$urandom_range(0, 32'h0000_FFFF), 16'h0} | 32'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(s, b, br, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
